wb_cpu_master: RTL
==================

Name: wb_cpu_master

Overview:
- Wishbone master bridge between the CPU data-memory port and the Wishbone peripheral slaves (LED/7-seg/switch/key/timer decoder).
- Turns a single-cycle CPU load/store request into one classic Wishbone cycle and stalls the CPU until the slave acks.
- Returns read data and a one-cycle done pulse.
- One outstanding transaction at a time; outputs registered.

Parameters:
- ADDR_WIDTH, 32, width of cpu_addr_i and wb_adr_o.
- TIMEOUT_CYCLES, 255, cycles spent in BUS with no ack before abort. Used only with WB_MASTER_TIMEOUT_EN; legal range 1..65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-low.
- cpu_req_i  in  1  request strobe, sampled only in IDLE.
- cpu_we_i  in  1  1=store, 0=load.
- cpu_addr_i  in  ADDR_WIDTH  byte address.
- cpu_wdata_i  in  32  store data, already lane-aligned by the CPU.
- cpu_sel_i  in  4  byte enables.
- cpu_rdata_o  out  32  load data, valid while cpu_done_o=1.
- cpu_done_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  timeout flag, qualified by cpu_done_o.
- cpu_stall_o  out  1  1 while a transaction is in flight.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_WIDTH  address, bits [1:0] forced to 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte select.
- wb_dat_i  in  32  read data from slave mux.
- wb_ack_i  in  1  slave ack; may be combinational on cyc&stb.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - wb_cyc_o/wb_stb_o/wb_we_o=0; wb_adr_o/wb_dat_o=0; wb_sel_o=4'h0.
  - cpu_rdata_o=0; cpu_done_o=0; cpu_err_o=0.
  - Reset asserted mid-transaction drops cyc/stb immediately. The aborted transaction never reports done.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If cpu_req_i=1 at an edge, latch we/addr/wdata/sel into the wb_*_o registers.
  - Set wb_cyc_o=wb_stb_o=1 and go to BUS.
  - A wb_ack_i seen in IDLE is ignored.
- BUS:
  - cyc/stb/we/adr/dat/sel are held constant.
  - On an edge with wb_ack_i=1: drop cyc/stb; for a load, register wb_dat_i into cpu_rdata_o; go to RESP.
  - Store: cpu_rdata_o is left unchanged.
- RESP:
  - cpu_done_o=1 for exactly this cycle; next state is IDLE unconditionally.
  - cpu_req_i during RESP is not accepted. The CPU re-presents the request in IDLE.
- cpu_stall_o = (state!=IDLE), combinational from the state register.
- Latency with a zero-wait slave (ack = cyc&stb):
  - req sampled at edge 0; cyc/stb high in cycle 1; ack in cycle 1.
  - done in cycle 2; next request accepted at the edge ending cycle 3.
  - One transaction every 3 cycles.
- Wait states: each cycle without ack extends BUS by 1; done = 2 + number of wait cycles.
- cpu_err_o is 0 except as described under Optional Feature.

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with still no ack: drop cyc/stb, set cpu_rdata_o=32'hDEAD_BEEF and cpu_err_o=1, go to RESP.
  - cpu_err_o clears on leaving RESP.
  - An ack on the same edge as the timeout wins: normal completion, err=0.
- Not defined: no counter; BUS waits indefinitely for ack; cpu_err_o tied 0.

Test Plan:
- Reset 0 for 3 cycles mid-BUS -> cyc/stb fall asynchronously; all outputs 0; no done pulse after release.
- Store, zero-wait slave: req we=1, addr=32'h1FD0_F000, wdata=32'h0000_A5A5, sel=4'hF -> cyc=stb=we=1 cycle 1, adr=32'h1FD0_F000, dat=32'h0000_A5A5; done cycle 2; stall high cycles 1-2.
- Load, 3 wait states: addr=32'h1FD0_F020, slave returns 32'h0000_003C -> ack cycle 4; done cycle 5; cpu_rdata_o=32'h0000_003C; adr/sel stable cycles 1-4.
- Address and back-to-back: addr=32'h1FD0_E003 -> wb_adr_o=32'h1FD0_E000. req held high continuously -> second cyc rises cycle 4; no req accepted in RESP.
- Spurious ack in IDLE -> no state change; cpu_done_o stays 0.
- With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 BUS cycles; done=1, err=1, rdata=32'hDEAD_BEEF. Without the macro -> cyc stays high for 1000 cycles.

Source files
------------

// File: rtl/wb_cpu_master.sv
// wb_cpu_master: turns a single-cycle CPU load/store into one classic Wishbone cycle.
// Optional no-ack bus timeout is compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_cpu_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    input  logic [3:0]            cpu_sel_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_done_o,
    output logic                  cpu_err_o,
    output logic                  cpu_stall_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_cyc, w_cyc_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_adr, w_adr_nxt;
    logic [31:0]           r_dat, w_dat_nxt;
    logic [3:0]            r_sel, w_sel_nxt;
    logic [31:0]           r_rdata, w_rdata_nxt;
    logic                  r_done, w_done_nxt;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= StIdle;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= 4'h0;
            r_rdata <= '0;
            r_done  <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_sel   <= w_sel_nxt;
            r_rdata <= w_rdata_nxt;
            r_done  <= w_done_nxt;
`ifdef WB_MASTER_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        w_sel_nxt   = r_sel;
        w_rdata_nxt = r_rdata;
        w_done_nxt  = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (cpu_req_i) begin
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = cpu_we_i;
                    // Word-aligned bus: low address bits are dropped here.
                    w_adr_nxt   = cpu_addr_i & ~ADDR_WIDTH'(3);
                    w_dat_nxt   = cpu_wdata_i;
                    w_sel_nxt   = cpu_sel_i;
                    w_state_nxt = StBus;
`ifdef WB_MASTER_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            StBus: begin
                if (wb_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StResp;
                    if (!r_we) begin
                        w_rdata_nxt = wb_dat_i;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    w_cyc_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 32'hDEAD_BEEF;
                    w_state_nxt = StResp;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
`endif
                end
            end
            StResp: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    assign cpu_rdata_o = r_rdata;
    assign cpu_done_o  = r_done;
    assign cpu_stall_o = (r_state != StIdle);
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = r_sel;

`ifdef WB_MASTER_TIMEOUT_EN
    assign cpu_err_o = r_err;
`else
    assign cpu_err_o = 1'b0;
`endif

endmodule
